// File: rtl/capture_ctrl.sv
// Logic-analyzer capture sequencer: arm, pre-trigger fill, trigger wait, post-trigger fill,
// then oldest-first readout of the sample SRAM as a valid/ready stream (one word per 3+ cycles).
module capture_ctrl #(
    parameter int DATA_LEN = 32,
    parameter int DEPTH    = 1024,
    parameter int ADDR_LEN = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arm,
    input  logic                abort,
    input  logic [ADDR_LEN-1:0] pre_len,
    input  logic [DATA_LEN-1:0] sample_i,
    input  logic                sample_vld,
    input  logic                trig,
    output logic                wr_en,
    output logic [ADDR_LEN-1:0] wr_addr,
    output logic [DATA_LEN-1:0] wr_data,
    output logic                rd_en_n,
    output logic [ADDR_LEN-1:0] rd_addr,
    input  logic [DATA_LEN-1:0] ram_data,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                triggered,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_WAIT, S_POST, S_RD_REQ, S_RD_LAT, S_RD_OUT, S_DONE
    } state_t;

    localparam logic [ADDR_LEN-1:0] ONE  = ADDR_LEN'(1);
    localparam logic [ADDR_LEN-1:0] LAST = ADDR_LEN'(DEPTH - 1);

    state_t state, state_nxt;

    logic [ADDR_LEN-1:0] pre_q, post_len, wptr, rptr, cnt, rcnt;
    logic capturing, acc, arm_go, trig_hit, pre_last, post_last, rd_acc;

    // DEPTH is a power of two, so DEPTH-1-pre_q is just the bitwise complement
    assign post_len  = ~pre_q;
    assign capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    assign acc       = capturing && sample_vld && !abort;
    assign arm_go    = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign trig_hit  = (state == S_WAIT) && acc && trig;
    assign pre_last  = (state == S_PRE)  && acc && (cnt == pre_q - ONE);
    assign post_last = (state == S_POST) && acc && (cnt == post_len - ONE);
    assign rd_acc    = (state == S_RD_OUT) && out_ready && !abort;
    assign rd_addr   = rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (arm) state_nxt = (pre_len == '0) ? S_WAIT : S_PRE;
                S_PRE:          if (pre_last) state_nxt = S_WAIT;
                S_WAIT:         if (trig_hit) state_nxt = (pre_q == LAST) ? S_RD_REQ : S_POST;
                S_POST:         if (post_last) state_nxt = S_RD_REQ;
                S_RD_REQ:       state_nxt = S_RD_LAT;
                S_RD_LAT:       state_nxt = S_RD_OUT;
                S_RD_OUT:       if (out_ready) state_nxt = (rcnt == LAST) ? S_DONE : S_RD_REQ;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        rd_en_n = 1'b1;
        case (state)
            S_PRE, S_WAIT, S_POST, S_RD_LAT, S_RD_OUT: busy = 1'b1;
            S_RD_REQ: begin
                busy    = 1'b1;
                rd_en_n = 1'b0;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            pre_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            triggered <= 1'b0;
        end else begin
            wr_en <= acc;
            if (acc) begin
                wr_addr <= wptr;
                wr_data <= sample_i;
                wptr    <= wptr + ONE;
            end
            if (acc && ((state == S_PRE) || (state == S_POST)))
                cnt <= cnt + ONE;
            if (arm_go) begin
                pre_q     <= pre_len;
                wptr      <= '0;
                cnt       <= '0;
                triggered <= 1'b0;
            end
            // oldest kept sample sits pre_q words behind the trigger sample
            if (trig_hit) begin
                triggered <= 1'b1;
                rptr      <= wptr - pre_q;
                cnt       <= '0;
                rcnt      <= '0;
            end
            if (state == S_RD_LAT) begin
                out_data  <= ram_data;
                out_valid <= 1'b1;
            end
            if (rd_acc) begin
                out_valid <= 1'b0;
                rptr      <= rptr + ONE;
                rcnt      <= rcnt + ONE;
            end
            if (abort) begin
                out_valid <= 1'b0;
                triggered <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Randomized scoreboard bench for capture_ctrl: expected readout is the last DEPTH accepted samples.
module tb_capture_ctrl;
    localparam int DL    = 32;
    localparam int DEPTH = 16;
    localparam int AL    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst, arm, abort, sample_vld, trig, out_ready;
    logic [AL-1:0] pre_len;
    logic [DL-1:0] sample_i;
    logic          wr_en, rd_en_n, out_valid, busy, triggered, done;
    logic [AL-1:0] wr_addr, rd_addr;
    logic [DL-1:0] wr_data, ram_data, out_data;

    logic [DL-1:0] mem [DEPTH];
    logic [DL-1:0] exp_q [$];
    int n_tests = 0, n_fail = 0, n_pop = 0;
    bit hold_prev = 1'b0;
    logic [DL-1:0] hold_data;

    capture_ctrl #(.DATA_LEN(DL), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort), .pre_len(pre_len),
        .sample_i(sample_i), .sample_vld(sample_vld), .trig(trig),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_n(rd_en_n), .rd_addr(rd_addr), .ram_data(ram_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    // behavioural dual-port SRAM, read data one cycle after the read
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (!rd_en_n) ram_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [DL-1:0] act, input logic [DL-1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: pops the scoreboard on every accepted word, checks stability while stalled
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (hold_prev) begin
                chk("stall_stable", out_data, hold_data);
                chk("stall_rd_en_n", rd_en_n, 1);
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word: got %0h expected none", out_data);
                end else begin
                    chk("readout", out_data, exp_q.pop_front());
                end
                n_pop++;
            end
            hold_prev = !out_ready;
            hold_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic run_capture(input int pre, input int t1, input int t2, input bit rnd, input bit stall10);
        logic [DL-1:0] smp [$];
        int idx, tidx, post, cyc, base, stall_cnt;
        bit fin, v, tg;
        logic [DL-1:0] d;
        post = DEPTH - 1 - pre;
        idx = 0; tidx = -1; fin = 0; cyc = 0;
        arm = 1; pre_len = AL'(pre); trig = 1;
        sample_vld = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        sample_i = 32'hdead_beef;
        step();
        arm = 0;
        chk("busy_after_arm", busy, 1);
        chk("trig_cleared", triggered, 0);
        while (!fin && cyc < 400) begin
            v  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = rnd ? $urandom : DL'(idx);
            tg = rnd ? ($urandom_range(0, 9) == 0 || idx >= pre + 40) : (idx == t1 || idx == t2);
            sample_vld = v; sample_i = d; trig = tg;
            if (v) begin
                smp.push_back(d);
                if (tidx < 0 && tg && idx >= pre) tidx = idx;
                if (tidx >= 0 && idx == tidx + post) fin = 1;
                idx++;
            end
            if (fin)
                for (int k = smp.size() - DEPTH; k < smp.size(); k++) exp_q.push_back(smp[k]);
            step();
            cyc++;
        end
        chk("capture_finished", 32'(fin), 1);
        sample_vld = rnd; trig = rnd; sample_i = $urandom;
        chk("rd_req_next", rd_en_n, 0);
        chk("triggered_set", triggered, 1);
        chk("last_write", wr_en, 1);
        cyc = 0; base = n_pop; stall_cnt = 0;
        while (!done && cyc < 2000) begin
            if (stall10 && (n_pop - base) >= 5 && stall_cnt < 10) begin
                out_ready = 0;
                stall_cnt++;
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rnd) begin
                sample_vld = 1'($urandom_range(0, 1));
                sample_i = $urandom;
            end
            step();
            cyc++;
        end
        out_ready = 1; sample_vld = 0; trig = 0;
        chk("done", done, 1);
        chk("busy_in_done", busy, 0);
        chk("triggered_hold", triggered, 1);
        chk("words_read", n_pop - base, DEPTH);
        chk("scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1; arm = 0; abort = 0; pre_len = '0; sample_i = '0;
        sample_vld = 0; trig = 0; out_ready = 1;
        #2;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en_n", rd_en_n, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_done", done, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_data", out_data, 0);
        step(); step();
        rst = 0;
        step();

        run_capture(4, 10, -1, 0, 0);
        run_capture(0, 0, -1, 0, 0);
        run_capture(4, 2, 7, 0, 0);
        run_capture(15, 20, -1, 0, 0);
        run_capture(4, 10, -1, 0, 1);

        // abort in POST, then arm together with abort
        arm = 1; pre_len = 4; step(); arm = 0;
        sample_vld = 1;
        for (int i = 0; i < 8; i++) begin
            sample_i = i; trig = (i == 5);
            step();
        end
        trig = 0;
        chk("post_busy", busy, 1);
        abort = 1; step(); abort = 0;
        chk("abort_busy", busy, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_triggered", triggered, 0);
        chk("abort_rd_en_n", rd_en_n, 1);
        chk("abort_out_valid", out_valid, 0);
        step();
        chk("idle_no_write", wr_en, 0);
        arm = 1; abort = 1; step(); arm = 0; abort = 0;
        chk("arm_abort_busy", busy, 0);
        step();
        chk("arm_abort_idle", busy, 0);
        chk("arm_abort_no_write", wr_en, 0);
        sample_vld = 0;

        for (int r = 0; r < 6; r++) run_capture($urandom_range(0, DEPTH - 1), -1, -1, 1, 0);

        // asynchronous reset in the middle of a capture
        arm = 1; pre_len = 3; step(); arm = 0;
        sample_vld = 1;
        step(); step();
        rst = 1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        step();
        rst = 0; sample_vld = 0;
        step();
        run_capture(2, 5, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
